// File: rtl/serial_crc8_pkg.sv
// Shared definitions for the bit-serial CRC-8 framer.
//   CRC_W        : CRC register width.
//   DEFAULT_POLY : default generator polynomial (x^8 term implicit).
//   DEFAULT_INIT : default CRC seed, loaded at reset and at every frame start.
//   state_t      : framer FSM state encoding (StIdle, StData, StCrc).
package serial_crc8_pkg;

  localparam int unsigned CRC_W = 8;

  localparam logic [CRC_W-1:0] DEFAULT_POLY = 8'h07;
  localparam logic [CRC_W-1:0] DEFAULT_INIT = 8'h00;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;  // no frame open
  localparam state_t StData = 2'd1;  // frame open, passing data through
  localparam state_t StCrc  = 2'd2;  // appending the checksum

endpackage

// File: rtl/crc8_step.sv
// One-bit CRC-8 update, purely combinational XOR network (MSB-first shift).
// Ports:
//   crc_in   : current CRC register value.
//   bit_in   : incoming data bit.
//   crc_next : CRC value after folding in bit_in.
// Parameter POLY selects the generator polynomial (implicit x^8 term).
module crc8_step
  import serial_crc8_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = DEFAULT_POLY
) (
  input  logic [CRC_W-1:0] crc_in,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc_next
);

  logic feedback;

  assign feedback = crc_in[CRC_W-1] ^ bit_in;
  assign crc_next = {crc_in[CRC_W-2:0], 1'b0} ^ ({CRC_W{feedback}} & POLY);

endmodule

// File: rtl/serial_crc8_framer.sv
// Bit-serial framer: passes data bits through and appends a CRC-8, MSB-first,
// after the bit flagged with up_last. Valid/ready handshake on both sides.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset.
//   up_valid/up_data/up_last    : upstream bit, with end-of-frame marker.
//   up_ready                    : upstream bit accepted this cycle.
//   down_valid/down_data        : output bit (data or CRC).
//   down_last                   : marks the final CRC bit of a frame.
//   down_ready                  : downstream accepts the output bit.
// Build option: define SERIAL_CRC8_FINAL_XOR_EN to emit the inverted CRC.
// The internal CRC register is the same in both builds.
module serial_crc8_framer
  import serial_crc8_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = DEFAULT_POLY,
  parameter logic [CRC_W-1:0] INIT = DEFAULT_INIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic up_valid,
  input  logic up_data,
  input  logic up_last,
  output logic up_ready,
  output logic down_valid,
  output logic down_data,
  output logic down_last,
  input  logic down_ready
);

  state_t           state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             data_q, data_d;
  logic             last_q, last_d;

  logic [CRC_W-1:0] crc_next;
  logic [CRC_W-1:0] crc_out;
  logic [2:0]       bit_idx;
  logic             slot_free;
  logic             up_fire;
  logic             down_fire;

  crc8_step #(
    .POLY(POLY)
  ) u_crc8_step (
    .crc_in  (crc_q),
    .bit_in  (up_data),
    .crc_next(crc_next)
  );

`ifdef SERIAL_CRC8_FINAL_XOR_EN
  assign crc_out = ~crc_q;
`else
  assign crc_out = crc_q;
`endif

  // Output register can take a new bit when empty or being drained this cycle.
  assign slot_free = !valid_q | down_ready;
  assign up_ready  = slot_free & (state_q != StCrc);
  assign up_fire   = up_valid & up_ready;
  assign down_fire = valid_q & down_ready;
  assign bit_idx   = 3'd7 - cnt_q;

  assign down_valid = valid_q;
  assign down_data  = data_q;
  assign down_last  = last_q;

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;

    if (up_fire) begin
      valid_d = 1'b1;
      data_d  = up_data;
      last_d  = 1'b0;
      crc_d   = crc_next;
      if (up_last) begin
        state_d = StCrc;
        cnt_d   = 3'd0;
      end else begin
        state_d = StData;
      end
    end else if ((state_q == StCrc) && slot_free) begin
      valid_d = 1'b1;
      data_d  = crc_out[bit_idx];
      last_d  = (cnt_q == 3'd7);
      if (cnt_q == 3'd7) begin
        // Re-seed now so a new frame can start while the last CRC bit drains.
        state_d = StIdle;
        crc_d   = INIT;
        cnt_d   = 3'd0;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end else if (down_fire) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      crc_q   <= INIT;
      cnt_q   <= 3'd0;
      valid_q <= 1'b0;
      data_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_serial_crc8_framer.sv
// Self-checking bench for serial_crc8_framer. Expected output bits are pushed
// to a scoreboard queue as stimulus is queued and popped on each down_fire.
module tb_serial_crc8_framer;

  typedef struct packed {
    logic d;
    logic l;
  } bit_t;

  logic clk;
  logic rst_n;
  logic up_valid;
  logic up_data;
  logic up_last;
  logic up_ready;
  logic down_valid;
  logic down_data;
  logic down_last;
  logic down_ready;

  int total;
  int bad;

  bit_t up_q[$];
  bit_t exp_q[$];

  serial_crc8_framer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .up_valid  (up_valid),
    .up_data   (up_data),
    .up_last   (up_last),
    .up_ready  (up_ready),
    .down_valid(down_valid),
    .down_data (down_data),
    .down_last (down_last),
    .down_ready(down_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Emitted CRC as seen on the wire for a given register value.
  function automatic logic [7:0] wire_crc(input logic [7:0] c);
`ifdef SERIAL_CRC8_FINAL_XOR_EN
    return ~c;
`else
    return c;
`endif
  endfunction

  // Queue one data byte MSB-first (up_last on bit 0) and its pass-through bits.
  task automatic push_byte(input logic [7:0] b);
    bit_t t;
    for (int i = 7; i >= 0; i--) begin
      t.d = b[i];
      t.l = (i == 0);
      up_q.push_back(t);
      t.l = 1'b0;
      exp_q.push_back(t);
    end
  endtask

  // Queue the expected 8 CRC bits, down_last on the final one.
  task automatic push_crc(input logic [7:0] c);
    bit_t t;
    logic [7:0] w;
    w = wire_crc(c);
    for (int i = 7; i >= 0; i--) begin
      t.d = w[i];
      t.l = (i == 0);
      exp_q.push_back(t);
    end
  endtask

  task automatic drive_up();
    if (up_q.size() != 0) begin
      up_valid = 1'b1;
      up_data  = up_q[0].d;
      up_last  = up_q[0].l;
    end else begin
      up_valid = 1'b0;
      up_data  = 1'b0;
      up_last  = 1'b0;
    end
  endtask

  task automatic test_reset();
    bit_t e;
    int   acc;
    int   cyc;
    rst_n      = 1'b0;
    up_valid   = 1'b0;
    up_data    = 1'b0;
    up_last    = 1'b0;
    down_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (down_valid !== 1'b0) begin
      bad++; $display("FAIL reset_down_valid got=%b want=0", down_valid);
    end
    total++;
    if (down_data !== 1'b0) begin
      bad++; $display("FAIL reset_down_data got=%b want=0", down_data);
    end
    total++;
    if (down_last !== 1'b0) begin
      bad++; $display("FAIL reset_down_last got=%b want=0", down_last);
    end
    total++;
    if (up_ready !== 1'b1) begin
      bad++; $display("FAIL reset_up_ready got=%b want=1", up_ready);
    end
    rst_n = 1'b1;

    // Start a 0x80 frame, then reset after four accepted bits.
    up_q.delete();
    exp_q.delete();
    push_byte(8'h80);
    acc = 0;
    cyc = 0;
    while (acc < 4 && cyc < 50) begin
      @(negedge clk);
      down_ready = 1'b1;
      drive_up();
      #1;
      if (up_valid && up_ready) begin
        void'(up_q.pop_front());
        acc++;
      end
      cyc++;
    end
    @(negedge clk);
    up_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    total++;
    if ({down_valid, down_data, down_last, up_ready} !== 4'b0001) begin
      bad++;
      $display("FAIL midframe_reset got={v,d,l,rdy}=%b want=0001",
               {down_valid, down_data, down_last, up_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;

    up_q.delete();
    exp_q.delete();
    push_byte(8'h01);
    push_crc(8'h07);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      @(negedge clk);
      down_ready = 1'b1;
      drive_up();
      #1;
      if (down_valid && down_ready) begin
        e = exp_q.pop_front();
        total++;
        if ({down_data, down_last} !== e) begin
          bad++;
          $display("FAIL after_reset_bit got=%b%b want=%b%b", down_data, down_last, e.d, e.l);
        end
      end
      if (up_valid && up_ready) void'(up_q.pop_front());
      cyc++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL after_reset_timeout left=%0d want=0", exp_q.size());
    end
    // Nothing further may be emitted once the frame is done.
    @(negedge clk);
    up_valid = 1'b0;
    #1;
    total++;
    if (down_valid !== 1'b0) begin
      bad++; $display("FAIL after_reset_extra got=%b want=0", down_valid);
    end
  endtask

  task automatic test_byte_80();
    bit_t e;
    int   cyc;
    int   low;
    bit   counting;
    up_q.delete();
    exp_q.delete();
    push_byte(8'h80);
    push_crc(8'h89);
    cyc      = 0;
    low      = 0;
    counting = 1'b0;
    while (exp_q.size() != 0 && cyc < 200) begin
      @(negedge clk);
      down_ready = 1'b1;
      drive_up();
      #1;
      if (counting) begin
        if (up_ready === 1'b0) low++;
        else counting = 1'b0;
      end
      if (down_valid && down_ready) begin
        e = exp_q.pop_front();
        total++;
        if ({down_data, down_last} !== e) begin
          bad++;
          $display("FAIL byte80_bit got=%b%b want=%b%b", down_data, down_last, e.d, e.l);
        end
      end
      if (up_valid && up_ready) begin
        if (up_last) counting = 1'b1;
        void'(up_q.pop_front());
      end
      cyc++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL byte80_timeout left=%0d want=0", exp_q.size());
    end
    total++;
    if (low != 8) begin
      bad++; $display("FAIL byte80_overhead got=%0d want=8", low);
    end
  endtask

  task automatic test_one_bit();
    bit_t e;
    bit_t t;
    int   cyc;
    int   low;
    bit   counting;
    up_q.delete();
    exp_q.delete();
    t.d = 1'b1;
    t.l = 1'b1;
    up_q.push_back(t);
    t.l = 1'b0;
    exp_q.push_back(t);
    push_crc(8'h07);
    cyc      = 0;
    low      = 0;
    counting = 1'b0;
    while ((exp_q.size() != 0 || counting) && cyc < 200) begin
      @(negedge clk);
      down_ready = 1'b1;
      drive_up();
      #1;
      if (counting) begin
        if (up_ready === 1'b0) low++;
        else counting = 1'b0;
      end
      if (down_valid && down_ready) begin
        e = exp_q.pop_front();
        total++;
        if ({down_data, down_last} !== e) begin
          bad++;
          $display("FAIL onebit_bit got=%b%b want=%b%b", down_data, down_last, e.d, e.l);
        end
      end
      if (up_valid && up_ready) begin
        if (up_last) counting = 1'b1;
        void'(up_q.pop_front());
      end
      cyc++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL onebit_timeout left=%0d want=0", exp_q.size());
    end
    total++;
    if (low != 8) begin
      bad++; $display("FAIL onebit_overhead got=%0d want=8", low);
    end
  endtask

  task automatic test_backpressure();
    bit_t       e;
    int         cyc;
    bit         stalled;
    logic [2:0] held;
    up_q.delete();
    exp_q.delete();
    push_byte(8'h80);
    push_crc(8'h89);
    cyc     = 0;
    stalled = 1'b0;
    held    = 3'b000;
    while (exp_q.size() != 0 && cyc < 400) begin
      @(negedge clk);
      down_ready = ($urandom_range(0, 2) != 0);
      drive_up();
      #1;
      if (stalled) begin
        total++;
        if ({down_valid, down_data, down_last} !== held) begin
          bad++;
          $display("FAIL stall_hold got=%b want=%b", {down_valid, down_data, down_last}, held);
        end
      end
      stalled = down_valid && !down_ready;
      held    = {down_valid, down_data, down_last};
      if (down_valid && down_ready) begin
        e = exp_q.pop_front();
        total++;
        if ({down_data, down_last} !== e) begin
          bad++;
          $display("FAIL bp_bit got=%b%b want=%b%b", down_data, down_last, e.d, e.l);
        end
      end
      if (up_valid && up_ready) void'(up_q.pop_front());
      cyc++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL bp_timeout left=%0d want=0", exp_q.size());
    end
    // Drain: no extra bit may follow the last CRC bit.
    @(negedge clk);
    down_ready = 1'b1;
    up_valid   = 1'b0;
    #1;
    if (down_valid) begin
      @(negedge clk);
      #1;
    end
    total++;
    if (down_valid !== 1'b0) begin
      bad++; $display("FAIL bp_extra got=%b want=0", down_valid);
    end
  endtask

  task automatic test_back_to_back();
    bit_t e;
    int   cyc;
    int   acc;
    bit   seen;
    up_q.delete();
    exp_q.delete();
    push_byte(8'h01);
    push_crc(8'h07);
    push_byte(8'h80);
    push_crc(8'h89);
    cyc  = 0;
    acc  = 0;
    seen = 1'b0;
    while (exp_q.size() != 0 && cyc < 300) begin
      @(negedge clk);
      down_ready = 1'b1;
      drive_up();
      #1;
      if (down_valid && down_ready) begin
        e = exp_q.pop_front();
        total++;
        if ({down_data, down_last} !== e) begin
          bad++;
          $display("FAIL b2b_bit got=%b%b want=%b%b", down_data, down_last, e.d, e.l);
        end
      end
      if (up_valid && up_ready) begin
        if (acc == 8) begin
          seen = 1'b1;
          total++;
          if ({down_valid, down_last} !== 2'b11) begin
            bad++;
            $display("FAIL b2b_first_accept got={v,l}=%b want=11", {down_valid, down_last});
          end
        end
        void'(up_q.pop_front());
        acc++;
      end
      cyc++;
    end
    total++;
    if (exp_q.size() != 0 || !seen) begin
      bad++; $display("FAIL b2b_timeout left=%0d seen=%b want=0,1", exp_q.size(), seen);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_byte_80();
    test_one_bit();
    test_backpressure();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
